// File: rtl/pipeline_trace_buffer_if.sv
// rtl/pipeline_trace_buffer_if.sv - capture/readout bus of the pipeline trace buffer
// Optional rd_timestamp signal exists only when TRACE_TIMESTAMP_EN is defined.
interface pipeline_trace_buffer_if #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CHANNELS * DATA_W;

    logic          arm;
    logic          trigger;
    logic [SW-1:0] probe_data;
    logic          rd_req;
    logic          rd_valid;
    logic [SW-1:0] rd_data;
    logic [1:0]    state;
    logic          done;
    logic [CW-1:0] stored_count;
    logic [CW-1:0] rd_remaining;
    logic [AW-1:0] trig_index;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]   rd_timestamp;
`endif

    modport master (
        output arm, trigger, probe_data, rd_req,
        input  rd_valid, rd_data, state, done, stored_count, rd_remaining, trig_index
`ifdef TRACE_TIMESTAMP_EN
        , input rd_timestamp
`endif
    );

    modport slave (
        input  arm, trigger, probe_data, rd_req,
        output rd_valid, rd_data, state, done, stored_count, rd_remaining, trig_index
`ifdef TRACE_TIMESTAMP_EN
        , output rd_timestamp
`endif
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - circular probe capture around a trigger, oldest-first readout
// Define TRACE_TIMESTAMP_EN to store a free-running cycle count with every sample.
module pipeline_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CHANNELS * DATA_W;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] TRIG_OFS  = CW'(POST_TRIG + 1);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] post_cnt_q;
    logic [AW-1:0] trig_idx_q;
    logic [CW-1:0] stored_q;
    logic [CW-1:0] rem_q;
    logic          rd_valid_q;
    logic [SW-1:0] rd_data_q;
    logic [SW-1:0] mem [DEPTH];

    logic          wr_en;
    logic          go_done;
    logic [AW-1:0] wr_ptr_d;
    logic [CW-1:0] stored_d;
    logic [CW-1:0] trig_pos_d;

    always_comb begin
        wr_en      = (state_q == ARMED) || (state_q == POST);
        wr_ptr_d   = wr_ptr_q + 1'b1;
        stored_d   = (stored_q == FULL) ? FULL : stored_q + 1'b1;
        trig_pos_d = stored_d - TRIG_OFS;
        go_done    = ((state_q == ARMED) && bus.trigger && (POST_TRIG == 0)) ||
                     ((state_q == POST) && (post_cnt_q == POST_LAST));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.probe_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            trig_idx_q <= '0;
            stored_q   <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_d;
                stored_q <= stored_d;
            end
            // The sample written on the DONE transition is included in the snapshot.
            if (go_done) begin
                state_q    <= DONE;
                rd_ptr_q   <= wr_ptr_d - stored_d[AW-1:0];
                rem_q      <= stored_d;
                trig_idx_q <= trig_pos_d[AW-1:0];
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.arm) begin
                            state_q  <= ARMED;
                            stored_q <= '0;
                        end
                    end
                    ARMED: begin
                        if (bus.trigger) begin
                            state_q    <= POST;
                            post_cnt_q <= '0;
                        end
                    end
                    POST: begin
                        post_cnt_q <= post_cnt_q + 1'b1;
                    end
                    DONE: begin
                        if (bus.arm) begin
                            state_q  <= ARMED;
                            stored_q <= '0;
                            rem_q    <= '0;
                        end else if (bus.rd_req && (rem_q != '0)) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= mem[rd_ptr_q];
                            rd_ptr_q   <= rd_ptr_q + 1'b1;
                            rem_q      <= rem_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] rd_ts_q;
    logic [31:0] mem_ts [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_ts[wr_ptr_q] <= ts_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q    <= '0;
            rd_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if ((state_q == DONE) && !bus.arm && bus.rd_req && (rem_q != '0)) begin
                rd_ts_q <= mem_ts[rd_ptr_q];
            end
        end
    end

    assign bus.rd_timestamp = rd_ts_q;
`endif

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.state        = state_q;
    assign bus.done         = (state_q == DONE);
    assign bus.stored_count = stored_q;
    assign bus.rd_remaining = rem_q;
    assign bus.trig_index   = trig_idx_q;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - randomized self-checking bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;
    localparam int DW = 32;
    localparam int CH = 2;
    localparam int DP = 8;
    localparam int PT = 3;
    localparam int CW = $clog2(DP) + 1;
    localparam int AW = $clog2(DP);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_trace_buffer_if #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DP)) bus ();

    pipeline_trace_buffer #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DP), .POST_TRIG(PT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    int exp_stored;
    int exp_trig;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] tb_ts;
    logic [31:0] ts_trig;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1;
    end
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH*DW-1:0] sample_word(input logic [31:0] k);
        return {~k, k};
    endfunction

    // Captures samples 0..tk+PT counting from arm; trigger on sample tk.
    task automatic capture(input int tk, input bit trig_with_arm);
        int n;
        logic [CW-1:0] e_cnt;
        logic [AW-1:0] e_idx;
        bit was_done;
        n = tk + 1 + PT;
        was_done = bus.done;
        bus.arm = 1'b1;
        bus.trigger = trig_with_arm;
        bus.rd_req = was_done ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc();
        bus.arm = 1'b0;
        bus.trigger = 1'b0;
        checks++;
        if (bus.state !== 2'd1 || bus.rd_valid !== 1'b0 || bus.rd_remaining !== '0) begin
            errors++;
            $display("FAIL arm_entry state=%0d rd_valid=%0b rem=%0d required state=1 rd_valid=0 rem=0",
                     bus.state, bus.rd_valid, bus.rd_remaining);
        end
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            bus.probe_data = sample_word(32'(k));
            bus.trigger = (k == tk);
            bus.arm = 1'($urandom_range(0, 1));
            bus.rd_req = 1'($urandom_range(0, 1));
`ifdef TRACE_TIMESTAMP_EN
            if (k == tk) ts_trig = tb_ts;
`endif
            cyc();
            exp_q.push_back(32'(k));
            if (exp_q.size() > DP) void'(exp_q.pop_front());
            checks++;
            if (bus.done !== (k == n - 1) || bus.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL capture_done k=%0d done=%0b rd_valid=%0b required done=%0b rd_valid=0",
                         k, bus.done, bus.rd_valid, (k == n - 1));
            end
        end
        bus.trigger = 1'b0;
        bus.arm = 1'b0;
        bus.rd_req = 1'b0;
        exp_stored = (n < DP) ? n : DP;
        exp_trig = exp_stored - 1 - PT;
        e_cnt = CW'(exp_stored);
        e_idx = AW'(exp_trig);
        checks++;
        if (bus.stored_count !== e_cnt || bus.rd_remaining !== e_cnt || bus.trig_index !== e_idx
            || bus.state !== 2'd3) begin
            errors++;
            $display("FAIL capture_summary stored=%0d rem=%0d trig=%0d state=%0d required %0d %0d %0d 3",
                     bus.stored_count, bus.rd_remaining, bus.trig_index, bus.state, e_cnt, e_cnt, e_idx);
        end
    endtask

    task automatic readout(input bit b2b, input int extra);
        int n;
        logic [CH*DW-1:0] last;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] prev_ts;
        prev_ts = '0;
`endif
        n = exp_q.size();
        last = bus.rd_data;
        for (int i = 0; i < n + extra; i++) begin
            bus.rd_req = 1'b1;
            cyc();
            if (!b2b) bus.rd_req = 1'b0;
            checks++;
            if (i < n) begin
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== sample_word(exp_q[i])
                    || bus.rd_remaining !== CW'(n - 1 - i)) begin
                    errors++;
                    $display("FAIL read_sample i=%0d valid=%0b data=%h rem=%0d required valid=1 data=%h rem=%0d",
                             i, bus.rd_valid, bus.rd_data, bus.rd_remaining, sample_word(exp_q[i]), n - 1 - i);
                end
                last = sample_word(exp_q[i]);
`ifdef TRACE_TIMESTAMP_EN
                if (i > 0) begin
                    checks++;
                    if (bus.rd_timestamp !== prev_ts + 1) begin
                        errors++;
                        $display("FAIL ts_step i=%0d ts=%0d required %0d", i, bus.rd_timestamp, prev_ts + 1);
                    end
                end
                if (i == exp_trig) begin
                    checks++;
                    if (bus.rd_timestamp !== ts_trig) begin
                        errors++;
                        $display("FAIL ts_trigger ts=%0d required %0d", bus.rd_timestamp, ts_trig);
                    end
                end
                prev_ts = bus.rd_timestamp;
`endif
            end else if (bus.rd_valid !== 1'b0 || bus.rd_data !== last) begin
                errors++;
                $display("FAIL read_exhausted i=%0d valid=%0b data=%h required valid=0 data=%h",
                         i, bus.rd_valid, bus.rd_data, last);
            end
            if (!b2b) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    cyc();
                    checks++;
                    if (bus.rd_valid !== 1'b0 || bus.rd_data !== last) begin
                        errors++;
                        $display("FAIL read_gap valid=%0b data=%h required valid=0 data=%h",
                                 bus.rd_valid, bus.rd_data, last);
                    end
                end
            end
        end
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_remaining !== '0 || bus.state !== 2'd3) begin
            errors++;
            $display("FAIL read_end rem=%0d state=%0d required rem=0 state=3", bus.rd_remaining, bus.state);
        end
    endtask

    task automatic test_reset();
        #7;
        checks++;
        if ({bus.state, bus.done, bus.rd_valid, bus.stored_count, bus.rd_remaining, bus.trig_index} !== '0
            || bus.rd_data !== '0) begin
            errors++;
            $display("FAIL reset_initial state=%0d done=%0b valid=%0b stored=%0d required all 0",
                     bus.state, bus.done, bus.rd_valid, bus.stored_count);
        end
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.trigger = 1'($urandom_range(0, 1));
            bus.rd_req = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (bus.state !== 2'd0 || bus.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cycle=%0d state=%0d valid=%0b required 0 0", i, bus.state, bus.rd_valid);
            end
        end
        bus.trigger = 1'b0;
        bus.rd_req = 1'b0;
        bus.arm = 1'b1;
        cyc();
        bus.arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.probe_data = sample_word(32'(k));
            cyc();
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.stored_count !== '0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async state=%0d stored=%0d done=%0b valid=%0b required all 0",
                     bus.state, bus.stored_count, bus.done, bus.rd_valid);
        end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_wrapped();
        capture(10, 1'b0);
        readout(1'b0, 0);
    endtask

    task automatic test_early_trigger();
        capture(1, 1'b0);
        readout(1'b0, 0);
    endtask

    task automatic test_back_to_back();
        capture(9, 1'b1);
        readout(1'b1, 10 - exp_q.size());
    endtask

    task automatic test_reset_mid_post();
        capture(0, 1'b0);
        bus.arm = 1'b1;
        cyc();
        bus.arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.probe_data = sample_word(32'(k));
            bus.trigger = (k == 2);
            cyc();
        end
        bus.trigger = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.stored_count !== '0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_post state=%0d stored=%0d done=%0b required 0 0 0",
                     bus.state, bus.stored_count, bus.done);
        end
        cyc();
        reset = 1'b0;
        capture(0, 1'b0);
        readout(1'b0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            capture(int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
            readout(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        bus.arm = 1'b0;
        bus.trigger = 1'b0;
        bus.rd_req = 1'b0;
        bus.probe_data = '0;
        test_reset();
        test_wrapped();
        test_early_trigger();
        test_back_to_back();
        test_reset_mid_post();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
